// File: rtl/serie_paralelo_pkg.sv
// serie_paralelo_pkg: state encoding and default comma shared by the serial-to-parallel aligner
package serie_paralelo_pkg;
  localparam logic [1:0] HUNT = 2'd0;
  localparam logic [1:0] CHECK = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;
  localparam logic [31:0] DEFAULT_COMMA = 32'hBC;
endpackage

// File: rtl/sp_shift_window.sv
// sp_shift_window: serial shift window, word phase counter and comma compare
// i_clk/i_rst: clock and sync active-high reset; i_data: serial bit, MSB first
// i_resync: restart the phase so the next boundary falls WIDTH edges later
// o_nxt: window value after this edge; o_boundary: this edge samples a word LSB
// o_comma_hit: o_nxt equals COMMA
module sp_shift_window import serie_paralelo_pkg::*; #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] COMMA = WIDTH'(DEFAULT_COMMA)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_data,
  input  logic             i_resync,
  output logic [WIDTH-1:0] o_nxt,
  output logic             o_boundary,
  output logic             o_comma_hit
);
  localparam int PW = $clog2(WIDTH);
  logic [WIDTH-1:0] r_window;
  logic [PW-1:0] r_phase;
  assign o_nxt = {r_window[WIDTH-2:0], i_data};
  assign o_boundary = r_phase == PW'(WIDTH - 1);
  assign o_comma_hit = o_nxt == COMMA;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_window <= '0;
      r_phase <= '0;
    end else begin
      r_window <= o_nxt;
      r_phase <= (i_resync || o_boundary) ? '0 : r_phase + 1'b1;
    end
  end
endmodule

// File: rtl/serie_paralelo_align.sv
// serie_paralelo_align: comma-aligned serial-to-parallel deserialiser with lock FSM
// clk_8f: bit clock; reset: sync active-high; data_in: serial data, MSB first
// valid_out: pulse for a non-comma word while locked; parallel_out: last word
// locked: FSM in LOCKED; align_err: pulse on loss of lock
module serie_paralelo_align import serie_paralelo_pkg::*; #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] COMMA = WIDTH'(DEFAULT_COMMA),
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 4
) (
  input  logic             clk_8f,
  input  logic             reset,
  input  logic             data_in,
  output logic             valid_out,
  output logic [WIDTH-1:0] parallel_out,
  output logic             locked,
  output logic             align_err
);
  localparam int MX = (LOCK_COUNT > LOSS_COUNT) ? LOCK_COUNT : LOSS_COUNT;
  localparam int CW = $clog2(MX + 1);
  logic [1:0] r_state;
  logic [CW-1:0] r_cnt, r_miss, w_cnt_inc, w_miss_inc;
  logic [WIDTH-1:0] w_nxt;
  logic w_boundary, w_comma_hit, w_resync;
  // any comma seen while hunting re-phases the word counter
  assign w_resync = (r_state == HUNT) && w_comma_hit;
  sp_shift_window #(.WIDTH(WIDTH), .COMMA(COMMA)) u_window (
    .i_clk(clk_8f),
    .i_rst(reset),
    .i_data(data_in),
    .i_resync(w_resync),
    .o_nxt(w_nxt),
    .o_boundary(w_boundary),
    .o_comma_hit(w_comma_hit)
  );
  assign w_cnt_inc = (r_cnt == CW'(MX)) ? r_cnt : r_cnt + 1'b1;
  assign w_miss_inc = (r_miss == CW'(MX)) ? r_miss : r_miss + 1'b1;
  assign locked = r_state == LOCKED;
  always_ff @(posedge clk_8f) begin
    if (reset) begin
      r_state <= HUNT;
      r_cnt <= '0;
      r_miss <= '0;
      parallel_out <= '0;
      valid_out <= 1'b0;
      align_err <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      align_err <= 1'b0;
      case (r_state)
        HUNT: if (w_comma_hit) begin
          r_cnt <= CW'(1);
          r_state <= (LOCK_COUNT == 1) ? LOCKED : CHECK;
        end
        CHECK: if (w_boundary) begin
          r_cnt <= w_comma_hit ? w_cnt_inc : '0;
          r_state <= !w_comma_hit ? HUNT : (w_cnt_inc >= CW'(LOCK_COUNT)) ? LOCKED : CHECK;
        end
        LOCKED: if (w_boundary) begin
          parallel_out <= w_comma_hit ? '0 : w_nxt;
          valid_out <= !w_comma_hit;
          r_miss <= w_comma_hit ? '0 : r_miss;
        end else if (w_comma_hit) begin
          // misses only accrue off-boundary, so the loss edge never carries a word
          if (w_miss_inc >= CW'(LOSS_COUNT)) begin
            r_state <= HUNT;
            align_err <= 1'b1;
            r_miss <= '0;
            r_cnt <= '0;
            parallel_out <= '0;
          end else begin
            r_miss <= w_miss_inc;
          end
        end
        default: r_state <= HUNT;
      endcase
    end
  end
endmodule

// File: tb/tb_serie_paralelo_align.sv
// tb_serie_paralelo_align: directed self-checking bench for serie_paralelo_align
module tb_serie_paralelo_align;
  logic clk = 1'b0, reset = 1'b1, data_in = 1'b0, d10 = 1'b0;
  logic valid_out, locked, align_err, v10, l10, e10;
  logic [7:0] pout, vdata;
  logic [9:0] p10;
  int errors = 0, checks = 0, vcount = 0, ecount = 0, cyc = 0, vcyc = 0;
  always #5 clk = ~clk;
  serie_paralelo_align dut (
    .clk_8f(clk), .reset(reset), .data_in(data_in),
    .valid_out(valid_out), .parallel_out(pout), .locked(locked), .align_err(align_err)
  );
  serie_paralelo_align #(.WIDTH(10), .COMMA(10'h17C), .LOCK_COUNT(2)) dut10 (
    .clk_8f(clk), .reset(reset), .data_in(d10),
    .valid_out(v10), .parallel_out(p10), .locked(l10), .align_err(e10)
  );
  task automatic send_bit(input logic b);
    data_in = b;
    @(posedge clk);
    #1;
    cyc++;
    if (valid_out) begin
      vcount++;
      vdata = pout;
      vcyc = cyc;
    end
    if (align_err) ecount++;
  endtask
  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
  endtask
  task automatic send10(input logic [9:0] w);
    for (int i = 9; i >= 0; i--) begin
      d10 = w[i];
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_reset;
    reset = 1'b1;
    data_in = 1'b1;
    d10 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    data_in = 1'b0;
    d10 = 1'b0;
  endtask
  task automatic lock4;
    do_reset();
    repeat (4) send_word(8'hBC);
  endtask
  task automatic test_reset;
    do_reset();
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_out); end
    checks++; if (pout !== 8'h00) begin errors++; $display("FAIL reset_pout: got %h want 00", pout); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b want 0", locked); end
    checks++; if (align_err !== 1'b0) begin errors++; $display("FAIL reset_align_err: got %b want 0", align_err); end
    checks++; if (l10 !== 1'b0 || p10 !== 10'h0 || v10 !== 1'b0 || e10 !== 1'b0) begin errors++; $display("FAIL reset_w10: locked=%b pout=%h valid=%b err=%b want all 0", l10, p10, v10, e10); end
  endtask
  task automatic test_aligned;
    int v0, t0;
    do_reset();
    repeat (3) send_word(8'hBC);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL aligned_3commas_locked: got %b want 0", locked); end
    send_word(8'hBC);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL aligned_4commas_locked: got %b want 1", locked); end
    v0 = vcount;
    send_word(8'h5A);
    checks++; if (valid_out !== 1'b1 || pout !== 8'h5A) begin errors++; $display("FAIL aligned_5A: valid=%b pout=%h want 1 5a", valid_out, pout); end
    t0 = vcyc;
    send_word(8'h3C);
    checks++; if (valid_out !== 1'b1 || pout !== 8'h3C) begin errors++; $display("FAIL aligned_3C: valid=%b pout=%h want 1 3c", valid_out, pout); end
    checks++; if (vcyc - t0 !== 8) begin errors++; $display("FAIL aligned_spacing: got %0d want 8", vcyc - t0); end
    send_bit(1'b1);
    checks++; if (valid_out !== 1'b0 || pout !== 8'h3C) begin errors++; $display("FAIL aligned_hold: valid=%b pout=%h want 0 3c", valid_out, pout); end
    for (int i = 6; i >= 0; i--) send_bit(1'(8'hBC >> i));
    checks++; if (valid_out !== 1'b0 || pout !== 8'h00) begin errors++; $display("FAIL aligned_comma_clears: valid=%b pout=%h want 0 00", valid_out, pout); end
    checks++; if (vcount - v0 !== 2) begin errors++; $display("FAIL aligned_valid_count: got %0d want 2", vcount - v0); end
  endtask
  task automatic test_offset;
    int v0;
    do_reset();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    repeat (4) send_word(8'hBC);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL offset_locked: got %b want 1", locked); end
    v0 = vcount;
    send_word(8'hA5);
    checks++; if (valid_out !== 1'b1 || pout !== 8'hA5) begin errors++; $display("FAIL offset_A5: valid=%b pout=%h want 1 a5", valid_out, pout); end
    send_word(8'hBC);
    checks++; if (vcount - v0 !== 1) begin errors++; $display("FAIL offset_valid_count: got %0d want 1", vcount - v0); end
  endtask
  task automatic test_check_abort;
    int v0;
    do_reset();
    v0 = vcount;
    send_word(8'hBC);
    send_word(8'hBC);
    send_word(8'h11);
    checks++; if (locked !== 1'b0 || vcount !== v0) begin errors++; $display("FAIL abort_11: locked=%b valids=%0d want 0 0", locked, vcount - v0); end
    repeat (3) send_word(8'hBC);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL abort_3commas_locked: got %b want 0", locked); end
    send_word(8'hBC);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL abort_relock: got %b want 1", locked); end
    send_word(8'h77);
    checks++; if (vcount - v0 !== 1 || vdata !== 8'h77) begin errors++; $display("FAIL abort_77: valids=%0d data=%h want 1 77", vcount - v0, vdata); end
  endtask
  task automatic test_slip;
    int v0, e0;
    lock4();
    v0 = vcount;
    e0 = ecount;
    send_bit(1'b0);
    repeat (3) send_word(8'hBC);
    checks++; if (locked !== 1'b1 || ecount !== e0) begin errors++; $display("FAIL slip_3misses: locked=%b errs=%0d want 1 0", locked, ecount - e0); end
    send_word(8'hBC);
    checks++; if (align_err !== 1'b1 || locked !== 1'b0) begin errors++; $display("FAIL slip_loss: align_err=%b locked=%b want 1 0", align_err, locked); end
    checks++; if (vcount - v0 !== 4 || vdata !== 8'h5E) begin errors++; $display("FAIL slip_words: valids=%0d data=%h want 4 5e", vcount - v0, vdata); end
    checks++; if (pout !== 8'h00) begin errors++; $display("FAIL slip_pout_cleared: got %h want 00", pout); end
    repeat (3) send_word(8'hBC);
    checks++; if (locked !== 1'b0 || ecount - e0 !== 1) begin errors++; $display("FAIL slip_relock_early: locked=%b errs=%0d want 0 1", locked, ecount - e0); end
    send_word(8'hBC);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL slip_relock: got %b want 1", locked); end
  endtask
  task automatic test_reset_mid;
    int v0;
    lock4();
    send_word(8'h5A);
    checks++; if (pout !== 8'h5A) begin errors++; $display("FAIL mid_pre_pout: got %h want 5a", pout); end
    for (int i = 7; i >= 4; i--) send_bit(1'(8'h3C >> i));
    v0 = vcount;
    reset = 1'b1;
    data_in = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++; if (valid_out !== 1'b0 || pout !== 8'h00 || locked !== 1'b0 || align_err !== 1'b0) begin errors++; $display("FAIL mid_reset_outputs: valid=%b pout=%h locked=%b err=%b want 0 00 0 0", valid_out, pout, locked, align_err); end
    for (int i = 3; i >= 0; i--) send_bit(1'(8'h3C >> i));
    repeat (4) send_bit(1'b0);
    checks++; if (vcount !== v0 || locked !== 1'b0) begin errors++; $display("FAIL mid_partial: valids=%0d locked=%b want 0 0", vcount - v0, locked); end
  endtask
  task automatic test_width10;
    do_reset();
    send10(10'h17C);
    checks++; if (l10 !== 1'b0) begin errors++; $display("FAIL w10_1comma_locked: got %b want 0", l10); end
    send10(10'h17C);
    checks++; if (l10 !== 1'b1) begin errors++; $display("FAIL w10_locked: got %b want 1", l10); end
    send10(10'h2A5);
    checks++; if (v10 !== 1'b1 || p10 !== 10'h2A5) begin errors++; $display("FAIL w10_word: valid=%b pout=%h want 1 2a5", v10, p10); end
    d10 = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (v10 !== 1'b0 || p10 !== 10'h2A5) begin errors++; $display("FAIL w10_hold: valid=%b pout=%h want 0 2a5", v10, p10); end
  endtask
  initial begin
    test_reset();
    test_aligned();
    test_offset();
    test_check_abort();
    test_slip();
    test_reset_mid();
    test_width10();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
